// File: rtl/bus_watchdog_arb.sv
// Four-master round-robin bus arbiter with a per-grant watchdog that aborts a silent slave.
// Define ARB_WDT_EN to build the watchdog (counter, ABORT/DRAIN states, ERR_O/TMO_FLAG/TMO_MAS).
module bus_watchdog_arb #(
  parameter int TMO_CYC = 16,
  parameter int CNT_W   = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CYC0,
  input  logic       CYC1,
  input  logic       CYC2,
  input  logic       CYC3,
  input  logic       ACK_I,
  input  logic       ERR_I,
  input  logic       CLR_TMO,
  output logic       GNT0,
  output logic       GNT1,
  output logic       GNT2,
  output logic       GNT3,
  output logic [1:0] GNT,
  output logic       COMCYC,
  output logic       ERR_O,
  output logic       TMO_FLAG,
  output logic [1:0] TMO_MAS,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY    = 3'd1,
    ABORT   = 3'd2,
    DRAIN   = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] lmas_q, lmas_d;
  logic [3:0] cyc;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       found;
  logic       gnt_cyc;
  logic       granted;
  logic       timeout;

  assign cyc     = {CYC3, CYC2, CYC1, CYC0};
  assign gnt_cyc = cyc[gnt_q];

  // Round-robin: search starts just after the last master that released the bus.
  always_comb begin
    win_idx = lmas_q + 2'd1;
    found   = 1'b0;
    cand    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = lmas_q + 2'(k);
      if (!found && cyc[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    lmas_d  = lmas_q;
    case (state_q)
      IDLE: begin
        if (|cyc) begin
          state_d = BUSY;
          gnt_d   = win_idx;
        end
      end
      BUSY: begin
        if (!gnt_cyc) begin
          state_d = RELEASE;
          lmas_d  = gnt_q;
        end else if (timeout) begin
          state_d = ABORT;
        end
      end
`ifdef ARB_WDT_EN
      ABORT: begin
        if (!gnt_cyc) begin
          state_d = RELEASE;
          lmas_d  = gnt_q;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!gnt_cyc) begin
          state_d = RELEASE;
          lmas_d  = gnt_q;
        end
      end
`endif
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      lmas_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      lmas_q  <= lmas_d;
    end
  end

  assign granted     = (state_q == BUSY) || (state_q == ABORT) || (state_q == DRAIN);
  assign GNT0        = granted && (gnt_q == 2'd0);
  assign GNT1        = granted && (gnt_q == 2'd1);
  assign GNT2        = granted && (gnt_q == 2'd2);
  assign GNT3        = granted && (gnt_q == 2'd3);
  assign GNT         = granted ? gnt_q : 2'd0;
  assign COMCYC      = (state_q == BUSY) && gnt_cyc;
  assign dbg_state_o = state_q;

`ifdef ARB_WDT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_flag_q, tmo_flag_d;
  logic [1:0]       tmo_mas_q, tmo_mas_d;

  assign timeout = !ACK_I && !ERR_I && (cnt_q == TMO_LAST);

  // Counter only moves while BUSY; any slave termination restarts the silence window.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == BUSY) begin
      cnt_d = '0;
    end else if (state_q == BUSY) begin
      if (ACK_I || ERR_I) cnt_d = '0;
      else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  // An abort in the same cycle as CLR_TMO keeps the flag set.
  always_comb begin
    tmo_flag_d = tmo_flag_q;
    tmo_mas_d  = tmo_mas_q;
    if (state_q == ABORT) begin
      tmo_flag_d = 1'b1;
      tmo_mas_d  = gnt_q;
    end else if (CLR_TMO) begin
      tmo_flag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q      <= '0;
      tmo_flag_q <= 1'b0;
      tmo_mas_q  <= 2'd0;
    end else begin
      cnt_q      <= cnt_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_mas_q  <= tmo_mas_d;
    end
  end

  assign ERR_O    = (state_q == ABORT);
  assign TMO_FLAG = tmo_flag_q;
  assign TMO_MAS  = tmo_mas_q;
`else
  logic unused_wdt_inputs;
  assign unused_wdt_inputs = ^{ACK_I, ERR_I, CLR_TMO};
  assign timeout  = 1'b0;
  assign ERR_O    = 1'b0;
  assign TMO_FLAG = 1'b0;
  assign TMO_MAS  = 2'd0;
`endif

endmodule
